// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: gain-scales a waveform sample and ships a 16-bit command frame to an SPI DAC once per sample period.
module dac_spi_serializer #(
    parameter int         SAMPLE_DIV = 1000,
    parameter int         CLK_DIV    = 2,
    parameter logic [3:0] CMD_BITS   = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] wave_in,
    input  logic [7:0]  gain,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        busy,
    output logic        sample_tick,
    output logic        overrun
);
    localparam int CW = $clog2(SAMPLE_DIV + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dcnt, dcnt_d;
    logic [3:0]    bitn, bitn_d;
    logic          hi, hi_d;
    logic [15:0]   frame, frame_d;
    logic          cs_d, sclk_d, mosi_d;
    logic          tick, last;
    logic [23:0]   product;
    logic [15:0]   scaled, new_frame;

    assign tick      = enable && cnt == CW'(SAMPLE_DIV - 1);
    assign last      = dcnt == DW'(CLK_DIV - 1);
    assign product   = 24'(wave_in) * 24'(gain);
    assign scaled    = product[23] ? 16'hFFFF : product[22:7];
    assign new_frame = {CMD_BITS, scaled[15:4]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (!enable || tick) ? '0 : cnt + CW'(1);
    end

    // dcnt paces every CLK_DIV-long phase; hi selects the sclk half within a bit
    always_comb begin
        state_d = state;
        dcnt_d  = (state == IDLE || last) ? '0 : dcnt + DW'(1);
        bitn_d  = bitn;
        hi_d    = hi;
        frame_d = frame;
        cs_d    = dac_cs_n;
        sclk_d  = dac_sclk;
        mosi_d  = dac_mosi;
        case (state)
            IDLE: if (tick) begin
                state_d = SETUP;
                frame_d = new_frame;
                cs_d    = 1'b0;
                mosi_d  = new_frame[15];
            end
            SETUP: if (last) begin
                state_d = SHIFT;
                bitn_d  = 4'd15;
                hi_d    = 1'b0;
            end
            SHIFT: if (last) begin
                if (!hi) begin
                    hi_d   = 1'b1;
                    sclk_d = 1'b1;
                end else begin
                    hi_d   = 1'b0;
                    sclk_d = 1'b0;
                    if (bitn == 4'd0) begin
                        state_d = HOLD;
                    end else begin
                        bitn_d = bitn - 4'd1;
                        mosi_d = frame[bitn - 4'd1];
                    end
                end
            end
            HOLD: if (last) begin
                state_d = GAP;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
            end
            GAP: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dcnt        <= '0;
            bitn        <= 4'd0;
            hi          <= 1'b0;
            frame       <= 16'h0;
            dac_cs_n    <= 1'b1;
            dac_sclk    <= 1'b0;
            dac_mosi    <= 1'b0;
            busy        <= 1'b0;
            sample_tick <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            dcnt        <= dcnt_d;
            bitn        <= bitn_d;
            hi          <= hi_d;
            frame       <= frame_d;
            dac_cs_n    <= cs_d;
            dac_sclk    <= sclk_d;
            dac_mosi    <= mosi_d;
            busy        <= state_d != IDLE;
            sample_tick <= tick && state == IDLE;
            overrun     <= tick && state != IDLE;
        end
    end
endmodule

// File: doc/dac_spi_serializer.md
# dac_spi_serializer

Downstream consumer of the waveform multiplexer output: takes the selected 16-bit unsigned waveform sample, applies a digital amplitude gain with saturation, and ships one 12-bit code per sample period to an external SPI DAC. It owns the audio/scope sample-rate timebase for the generator chain and reports dropped samples when a frame cannot start on time.

## Interface
- SAMPLE_DIV, 1000, clk cycles per output sample; must be ≥ 35*CLK_DIV+1 for overrun-free operation
- CLK_DIV, 2, clk cycles per SCLK half-period; ≥ 1
- CMD_BITS, 4'b0011, 4-bit DAC control nibble sent as frame bits [15:12]

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  runs the sample timebase; low holds the counter at 0
- wave_in  in  16  unsigned waveform sample from the selector
- gain  in  8  amplitude gain, unsigned, 128 = unity (gain/128)
- dac_cs_n  out  1  SPI chip select, active low
- dac_sclk  out  1  SPI clock, idle low, DAC samples on the rising edge
- dac_mosi  out  1  SPI data, MSB first
- busy  out  1  high whenever state ≠ IDLE
- sample_tick  out  1  one-cycle pulse when a sample is captured and a frame starts
- overrun  out  1  one-cycle pulse when a sample tick is dropped because a frame is in progress

## Operation
- Timebase: cnt counts 0..SAMPLE_DIV-1 while enable=1, wraps to 0; tick = enable && cnt==SAMPLE_DIV-1. enable=0: cnt forced to 0, no ticks; a frame in progress completes normally.
- Arithmetic on tick: product = wave_in*gain (24 bits); if product[23]=1 then scaled = 16'hFFFF else scaled = product[22:7]; code = scaled[15:4] (truncate); frame = {CMD_BITS, code}.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: cs_n=1, sclk=0. On tick: capture frame, cs_n←0, mosi←frame[15], sample_tick←1, go SETUP.
  - SETUP: CLK_DIV cycles, sclk=0, then SHIFT at bit 15.
  - SHIFT: per bit i=15..0: sclk low CLK_DIV cycles then high CLK_DIV cycles; mosi=frame[i] for the whole bit, updated on the edge that drops sclk (start of next bit's low phase). After bit 0's high phase: sclk←0, go HOLD.
  - HOLD: CLK_DIV cycles, cs_n=0, sclk=0; then cs_n←1, mosi←0, go GAP.
  - GAP: CLK_DIV cycles, cs_n=1; then IDLE.
- Tick in any state ≠ IDLE: sample not captured, sample_tick stays 0, overrun←1 for one cycle; the frame is not disturbed. The timebase keeps running regardless of FSM state.
- wave_in and gain are sampled only on the tick edge; changes mid-frame have no effect.

## Timing
- Reset values: dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, sample_tick=0, overrun=0, cnt=0, state IDLE. Reset mid-frame aborts immediately (cs_n rises asynchronously); no partial frame resumes after release.
- All outputs registered, glitch-free.
- Tick→cs_n fall: same edge that ends cnt=SAMPLE_DIV-1; sample_tick high on that same cycle.
- Frame length (cs_n low) = 34*CLK_DIV cycles; busy high 35*CLK_DIV cycles; exactly 16 sclk rising edges per frame.
- First tick occurs SAMPLE_DIV edges after enable is first sampled high.

## Test plan
- CLK_DIV=2, SAMPLE_DIV=100, wave_in=16'h8000, gain=128 -> 16 bits shifted = 16'h3800, cs_n low 68 cycles, busy high 70 cycles, sample_tick every 100 cycles.
- wave_in=16'hFFFF, gain=255 -> saturation, frame 16'h3FFF; gain=0 -> frame 16'h3000; wave_in=16'h1234, gain=64 -> scaled 16'h091A, frame 16'h3091.
- SAMPLE_DIV=50, CLK_DIV=2 -> every other tick produces overrun pulse, sample_tick only on captured ticks, frames intact and spaced 100 cycles.
- Change wave_in and gain every cycle during a frame -> shifted frame equals value captured at tick.
- Assert rst at bit 7 of SHIFT -> cs_n=1, sclk=0, mosi=0, busy=0 immediately; after release, first frame starts SAMPLE_DIV edges later with full 16 bits.
- Deassert enable mid-frame -> frame completes, no further ticks; re-enable -> next tick after SAMPLE_DIV edges.
